// File: rtl/jk_pkg.sv
// Shared constants and elaboration-time helpers for the JK pattern detector.
// The failure function is only ever evaluated on constants to build the next-state table.
package jk_pkg;

  localparam int MAX_N   = 8;
  localparam int CNT_MAX = 255;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Longest proper pattern prefix that ends the stream "first k pattern bits, then x".
  function automatic int fail_next(input logic [MAX_N-1:0] pattern, input int n,
                                   input int k, input logic x);
    int   best;
    int   t;
    logic ok;
    logic sb;
    best = 0;
    for (int j = 1; j <= n; j++) begin
      if (j <= k) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          t  = k + 1 - j + i;
          sb = x;
          if (t < k) sb = pattern[n-1-t];
          if (sb != pattern[n-1-i]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  function automatic int next_state(input logic [MAX_N-1:0] pattern, input int n,
                                    input bit overlap, input int k, input logic x);
    int r;
    if (k < n)
      r = (x == pattern[n-1-k]) ? k + 1 : fail_next(pattern, n, k, x);
    else if (overlap)
      r = fail_next(pattern, n, n, x);
    else
      r = (x == pattern[n-1]) ? 1 : 0;
    return r;
  endfunction

endpackage

// File: rtl/jk_ff.sv
// JK flip-flop: hold / reset / set / toggle on the rising edge, async clear to 0.
// Latency: one edge; backpressure: none.
module jk_ff (
  input  logic J,
  input  logic K,
  input  logic CLK,
  input  logic RESET_N,
  output logic Q
);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      Q <= 1'b0;
    end else begin
      case ({J, K})
        2'b00:   Q <= Q;
        2'b01:   Q <= 1'b0;
        2'b10:   Q <= 1'b1;
        default: Q <= ~Q;
      endcase
    end
  end

endmodule

// File: rtl/jk_pattern_detector.sv
// Serial N-bit pattern detector (MSB first) on a JK-flop state register, with match counter.
// Latency: F one edge after the last pattern bit; backpressure: none, en=0 freezes everything.
module jk_pattern_detector
  import jk_pkg::*;
#(
  parameter int               N       = 4,
  parameter logic [MAX_N-1:0] PATTERN = 8'b0000_1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = clog2(CNT_MAX + 1),
  localparam int              SW      = clog2(N + 1)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             x,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             F,
  output logic [SW-1:0]    S,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("jk_pattern_detector: N must be in 2..8");
  end
  if ((PATTERN >> N) != '0) begin : g_bad_pattern
    $error("jk_pattern_detector: PATTERN is wider than N");
  end

  logic [SW-1:0] nxt0 [N+1];
  logic [SW-1:0] nxt1 [N+1];
  logic [SW-1:0] nxt;
  logic [SW-1:0] d;
  logic [SW-1:0] j_in;
  logic [SW-1:0] k_in;
  logic          hit;

  // Whole transition table is constant; only the lookup is real logic.
  for (genvar k = 0; k <= N; k++) begin : g_tbl
    assign nxt0[k] = SW'(next_state(PATTERN, N, OVERLAP, k, 1'b0));
    assign nxt1[k] = SW'(next_state(PATTERN, N, OVERLAP, k, 1'b1));
  end

  always_comb begin
    nxt = '0;
    for (int k = 0; k <= N; k++) begin
      if (S == SW'(k)) nxt = x ? nxt1[k] : nxt0[k];
    end
  end

  assign d    = en ? nxt : S;
  assign j_in = ~S & d;
  assign k_in = S & ~d;

  for (genvar i = 0; i < SW; i++) begin : g_state
    jk_ff u_ff (
      .J       (j_in[i]),
      .K       (k_in[i]),
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .Q       (S[i])
    );
  end

  assign F       = (S == SW'(N));
  assign hit     = en & (nxt == SW'(N));
  assign cnt_sat = &match_cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      match_cnt <= '0;
    end else if (clr_cnt) begin
      match_cnt <= '0;
    end else if (hit && !cnt_sat) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/jk_pattern_detector.md
# jk_pattern_detector

Parametrised serial pattern detector and the next generation of the team's JK-flip-flop Moore machine. It replaces the fixed 3-bit single-sequence machine with a state register built from JK flip-flops that recognises any N-bit pattern, MSB first, with selectable overlapping or non-overlapping matching. It also adds an input enable and a saturating match counter. It sits on a single-bit serial input stream and raises a one-cycle detect flag per match.

## Interface
- N, 4: pattern length in bits, legal range 2..8.
- PATTERN, 4'b1011: N-bit pattern; bit N-1 is received first.
- OVERLAP, 1: 1 = overlapping matches allowed; 0 = matching restarts after each hit.
- CNT_W, 8: width of the match counter.
- SW, derived as clog2(N+1): state width; not user-overridable.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- x  in  1  serial data bit.
- en  in  1  sample enable; x is consumed only when en=1.
- clr_cnt  in  1  synchronous clear of the match counter.
- F  out  1  Moore detect flag; high while state == N.
- S  out  SW  current state (number of pattern bits currently matched, 0..N).
- match_cnt  out  CNT_W  number of matches since reset or clear; saturating.
- cnt_sat  out  1  high while match_cnt is all ones.

## Operation
- State k (0..N) means the last k consumed bits equal the first k pattern bits.
- From state k<N:
  - if x == PATTERN[N-1-k], go to k+1;
  - otherwise go to fail(k,x): the longest proper prefix of PATTERN that is a suffix of (matched k bits followed by x). This is the KMP failure function, resolved at elaboration time.
- From state N:
  - OVERLAP=1: treat as k=N using the failure function.
  - OVERLAP=0: restart, so next = 1 if x == PATTERN[N-1], else 0.
- en=0: state, F and match_cnt hold; x is ignored.
- State bits are JK flip-flops. Per bit: J = ~Q & D and K = Q & ~D, where D is the next-state bit, so hold uses J=K=0.
- F = (S == N); it is purely a function of state, with no combinational path from x.
- Counter:
  - increments by 1 on each edge where en=1 and next state == N;
  - saturates at 2^CNT_W-1, and cnt_sat asserts;
  - clr_cnt=1 forces 0 on the next edge; clear wins over a simultaneous increment.
- An elaboration-time check rejects N outside 2..8 and a PATTERN wider than N.

## Timing
- Reset (RESET_N low, asynchronous): S=0, F=0, match_cnt=0, cnt_sat=0 immediately. Release is sampled on the next rising edge.
- x and en are sampled on the rising edge. The testbench drives them away from the edge.
- Latency: F rises one edge after the last pattern bit is sampled and stays high for exactly one enabled cycle per match. With en=0 it stays high as long as en is held low.
- match_cnt updates on the same edge that F rises.
- Reset asserted mid-pattern discards the partial match. A reset coinciding with a match edge yields no count.
- Back-to-back overlapping matches (e.g. N=2, PATTERN=11, input 1111) keep F high on consecutive cycles.

## Structure
- Package jk_pkg:
  - state-width function clog2;
  - elaboration-time function fail_next(pattern, n, k, x), which returns the fallback state;
  - localparam CNT_MAX.
- Sub-module jk_ff (J, K, CLK, RESET_N, Q): asynchronous active-low reset to 0; per-edge behaviour hold / reset / set / toggle. Instantiated SW times.
- Next-state logic, J/K derivation, F decode and the counter live in the top module.

## Test plan
- Reset: drive RESET_N=0 mid-cycle -> S=0, F=0, match_cnt=0 without waiting for a clock; release, then x=0 for 5 cycles -> S stays 0.
- Overlap: N=4, PATTERN=1011, OVERLAP=1, stream 1,0,1,1,0,1,1 with en=1 -> S sequence 1,2,3,4,2,3,4; F pulses after bits 4 and 7; match_cnt=2.
- Non-overlap: same stream, OVERLAP=0 -> S sequence 1,2,3,4,0,1,1; F pulses once; match_cnt=1.
- Enable gating: PATTERN=1011, en=0 for 3 cycles between bits 2 and 3 with x toggling -> S holds 2; the match still completes; match_cnt=1.
- Counter: CNT_W=2, N=2, PATTERN=11, OVERLAP=1, ten 1s -> match_cnt saturates at 3 and cnt_sat=1; clr_cnt asserted on a match edge -> match_cnt=0.
- Reset mid-operation: PATTERN=1011, after bits 1,0,1 assert RESET_N=0 then release, feed 1 -> S=1 (not a match); F stays 0.
